cmd_tag_credit_ctrl: RTL and testbench

- Command-issue stage directly upstream of the PSL command interface, and the consumer of the PSL response interface.
- Accepts command requests from AFU engines over valid/ready.
- Allocates a tag from a free pool and gates issue on PSL credits (initial ha_croom, replenished by ha_rcredits).
- Drives the ah_c* bus with parity, and returns completed responses to engines while freeing tags.

---
 rtl/capi_pkg.sv | 31 +++
 rtl/tag_free_list.sv | 45 ++++
 rtl/cmd_tag_credit_ctrl.sv | 162 ++++++++++++++++
 tb/tb_cmd_tag_credit_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/capi_pkg.sv
// Shared PSL command/response widths, codes and helpers for the command-issue slice.
package capi_pkg;

  localparam int TAG_W   = 8;
  localparam int COM_W   = 13;
  localparam int EA_W    = 64;
  localparam int CSIZE_W = 12;

  localparam logic [COM_W-1:0] READ_CL_NA = 13'h0A00;
  localparam logic [COM_W-1:0] WRITE_NA   = 13'h0D00;
  localparam logic [COM_W-1:0] RESTART    = 13'h0001;

  localparam logic [7:0] DONE    = 8'h00;
  localparam logic [7:0] AERROR  = 8'h01;
  localparam logic [7:0] DERROR  = 8'h03;
  localparam logic [7:0] FLUSHED = 8'h06;
  localparam logic [7:0] FAULT   = 8'h07;
  localparam logic [7:0] PAGED   = 8'h0A;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  // Narrower fields are zero-extended by the caller; padding zeros do not change parity.
  function automatic logic odd_parity(input logic [63:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/tag_free_list.sv
// Tag pool: busy bitmap, lowest-index free tag selection and in-flight count.
module tag_free_list
  import capi_pkg::*;
#(
  parameter int NUM_TAGS = 32,
  parameter int CNT_W    = 9
) (
  input  logic                clock,
  input  logic                rstn,
  input  logic                flush,
  input  logic                alloc,
  input  logic                free,
  input  logic [TAG_W-1:0]    free_idx,
  output logic [TAG_W-1:0]    alloc_idx,
  output logic                any_free,
  output logic [NUM_TAGS-1:0] busy,
  output logic [CNT_W-1:0]    count
);

  // Selection uses the pre-edge bitmap, so a tag freed this cycle is only offered next cycle.
  always_comb begin
    alloc_idx = '0;
    any_free  = 1'b0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        alloc_idx = TAG_W'(i);
        any_free  = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!rstn || flush) begin
      busy  <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < NUM_TAGS; i++) begin
        if (alloc && alloc_idx == TAG_W'(i)) busy[i] <= 1'b1;
        if (free && free_idx == TAG_W'(i))   busy[i] <= 1'b0;
      end
      count <= count + CNT_W'(alloc) - CNT_W'(free);
    end
  end

endmodule

// File: rtl/cmd_tag_credit_ctrl.sv
// PSL command issue with tag allocation and credit gating; retires responses back to engines.
module cmd_tag_credit_ctrl
  import capi_pkg::*;
#(
  parameter int NUM_TAGS = 32,
  parameter int CNT_W    = 9
) (
  input  logic               clock,
  input  logic               rstn,
  input  logic               enabled,
  input  logic [7:0]         ha_croom,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [COM_W-1:0]   req_com,
  input  logic [EA_W-1:0]    req_cea,
  input  logic [15:0]        req_cch,
  input  logic [CSIZE_W-1:0] req_csize,
  output logic               ah_cvalid,
  output logic [TAG_W-1:0]   ah_ctag,
  output logic               ah_ctagpar,
  output logic [COM_W-1:0]   ah_com,
  output logic               ah_compar,
  output logic [2:0]         ah_cabt,
  output logic [EA_W-1:0]    ah_cea,
  output logic               ah_ceapar,
  output logic [15:0]        ah_cch,
  output logic [CSIZE_W-1:0] ah_csize,
  input  logic               ha_rvalid,
  input  logic [TAG_W-1:0]   ha_rtag,
  input  logic               ha_rtagpar,
  input  logic [7:0]         ha_response,
  input  logic [8:0]         ha_rcredits,
  output logic               rsp_valid,
  output logic [TAG_W-1:0]   rsp_tag,
  output logic [7:0]         rsp_code,
  output logic [CNT_W-1:0]   outstanding,
  output logic               err_tag
);

  state_t                  state, state_next;
  logic                    load, run;
  logic [CNT_W-1:0]        credits, max_credits;
  logic                    any_free, issue, parity_ok, tag_busy, rsp_hit, rsp_bad;
  logic [TAG_W-1:0]        alloc_tag;
  logic [NUM_TAGS-1:0]     busy;
  logic signed [CNT_W+1:0] rc_ext, dec, cred_sum;

  function automatic logic [CNT_W-1:0] sat_credits(input logic signed [CNT_W+1:0] s,
                                                   input logic [CNT_W-1:0] lim);
    if (s < 0) return '0;
    if (s > $signed({2'b00, lim})) return lim;
    return s[CNT_W-1:0];
  endfunction

  always_ff @(posedge clock) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    run        = 1'b0;
    case (state)
      IDLE: if (enabled) state_next = LOAD;
      LOAD: begin
        load       = 1'b1;
        state_next = RUN;
      end
      RUN:  run = 1'b1;
      default: state_next = IDLE;
    endcase
    // A flush cycle accepts nothing, so no command is handed over and then dropped.
    if (!enabled) begin
      state_next = IDLE;
      load       = 1'b0;
      run        = 1'b0;
    end
  end

  assign req_ready = run & (credits != '0) & any_free;
  assign issue     = req_valid & req_ready;
  assign ah_cabt   = 3'b000;

  always_comb begin
    tag_busy = 1'b0;
    for (int i = 0; i < NUM_TAGS; i++) begin
      if (busy[i] && ha_rtag == TAG_W'(i)) tag_busy = 1'b1;
    end
  end

  assign parity_ok = (odd_parity(64'(ha_rtag)) == ha_rtagpar);
  assign rsp_hit   = run & ha_rvalid & parity_ok & tag_busy;
  assign rsp_bad   = run & ha_rvalid & ~(parity_ok & tag_busy);

  assign rc_ext   = ha_rvalid ? {{(CNT_W-7){ha_rcredits[8]}}, ha_rcredits} : '0;
  assign dec      = issue ? '1 : '0;
  assign cred_sum = $signed({2'b00, credits}) + dec + rc_ext;

  always_ff @(posedge clock) begin
    if (!rstn || !enabled) begin
      credits     <= '0;
      max_credits <= '0;
    end else if (load) begin
      credits     <= CNT_W'(ha_croom);
      max_credits <= CNT_W'(ha_croom);
    end else if (run) begin
      credits     <= sat_credits(cred_sum, max_credits);
    end
  end

  tag_free_list #(.NUM_TAGS(NUM_TAGS), .CNT_W(CNT_W)) u_tags (
    .clock     (clock),
    .rstn      (rstn),
    .flush     (~enabled),
    .alloc     (issue),
    .free      (rsp_hit),
    .free_idx  (ha_rtag),
    .alloc_idx (alloc_tag),
    .any_free  (any_free),
    .busy      (busy),
    .count     (outstanding)
  );

  // Command and response output registers; parity is captured with the value it covers.
  always_ff @(posedge clock) begin
    if (!rstn) begin
      ah_cvalid  <= 1'b0;
      ah_ctag    <= '0;
      ah_ctagpar <= 1'b0;
      ah_com     <= '0;
      ah_compar  <= 1'b0;
      ah_cea     <= '0;
      ah_ceapar  <= 1'b0;
      ah_cch     <= '0;
      ah_csize   <= '0;
      rsp_valid  <= 1'b0;
      rsp_tag    <= '0;
      rsp_code   <= '0;
      err_tag    <= 1'b0;
    end else begin
      ah_cvalid <= issue;
      if (issue) begin
        ah_ctag    <= alloc_tag;
        ah_ctagpar <= odd_parity(64'(alloc_tag));
        ah_com     <= req_com;
        ah_compar  <= odd_parity(64'(req_com));
        ah_cea     <= req_cea;
        ah_ceapar  <= odd_parity(req_cea);
        ah_cch     <= req_cch;
        ah_csize   <= req_csize;
      end
      rsp_valid <= rsp_hit;
      if (rsp_hit) begin
        rsp_tag  <= ha_rtag;
        rsp_code <= ha_response;
      end
      if (rsp_bad) err_tag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cmd_tag_credit_ctrl.sv
// Scoreboard bench for cmd_tag_credit_ctrl: a cycle model queues expected commands/responses.
module tb_cmd_tag_credit_ctrl;

  localparam int NUM_TAGS = 32;
  localparam int CNT_W    = 9;

  logic clock = 1'b0;
  logic rstn, enabled, req_valid, req_ready;
  logic [7:0] ha_croom;
  logic [12:0] req_com, ah_com;
  logic [63:0] req_cea, ah_cea;
  logic [15:0] req_cch, ah_cch;
  logic [11:0] req_csize, ah_csize;
  logic ah_cvalid, ah_ctagpar, ah_compar, ah_ceapar;
  logic [7:0] ah_ctag;
  logic [2:0] ah_cabt;
  logic ha_rvalid, ha_rtagpar;
  logic [7:0] ha_rtag, ha_response;
  logic [8:0] ha_rcredits;
  logic rsp_valid, err_tag;
  logic [7:0] rsp_tag, rsp_code;
  logic [CNT_W-1:0] outstanding;

  always #5 clock = ~clock;

  cmd_tag_credit_ctrl #(.NUM_TAGS(NUM_TAGS), .CNT_W(CNT_W)) dut (
    .clock(clock), .rstn(rstn), .enabled(enabled), .ha_croom(ha_croom),
    .req_valid(req_valid), .req_ready(req_ready), .req_com(req_com), .req_cea(req_cea),
    .req_cch(req_cch), .req_csize(req_csize),
    .ah_cvalid(ah_cvalid), .ah_ctag(ah_ctag), .ah_ctagpar(ah_ctagpar), .ah_com(ah_com),
    .ah_compar(ah_compar), .ah_cabt(ah_cabt), .ah_cea(ah_cea), .ah_ceapar(ah_ceapar),
    .ah_cch(ah_cch), .ah_csize(ah_csize),
    .ha_rvalid(ha_rvalid), .ha_rtag(ha_rtag), .ha_rtagpar(ha_rtagpar),
    .ha_response(ha_response), .ha_rcredits(ha_rcredits),
    .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_code(rsp_code),
    .outstanding(outstanding), .err_tag(err_tag)
  );

  typedef struct {
    logic [7:0]  tag;
    logic [12:0] com;
    logic [63:0] cea;
    logic [15:0] cch;
    logic [11:0] csize;
  } cmd_t;
  typedef struct {
    logic [7:0] tag;
    logic [7:0] code;
  } rsp_t;

  cmd_t cmd_q[$];
  rsp_t rsp_q[$];

  int tests_run = 0;
  int tests_failed = 0;
  bit chk_en = 1'b0;

  bit [NUM_TAGS-1:0] mbusy;
  int mcred, mmax, mstate;
  bit merr;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic bit model_ready();
    return (mstate == 2) && enabled && (mcred > 0) && (mbusy != '1);
  endfunction

  // Reference model, sampled on the active edge with pre-edge inputs.
  always @(posedge clock) begin
    if (!rstn) begin
      mbusy = '0; mcred = 0; mmax = 0; mstate = 0; merr = 1'b0;
      cmd_q.delete(); rsp_q.delete();
    end else if (!enabled) begin
      mbusy = '0; mcred = 0; mstate = 0;
    end else if (mstate == 0) begin
      mstate = 1;
    end else if (mstate == 1) begin
      mcred = ha_croom; mmax = ha_croom; mstate = 2;
    end else begin
      bit [NUM_TAGS-1:0] nb;
      int delta, idx;
      bit good;
      nb = mbusy;
      delta = 0;
      if (req_valid && model_ready()) begin
        cmd_t c;
        for (int i = 0; i < NUM_TAGS; i++) begin
          if (!mbusy[i]) begin c.tag = 8'(i); break; end
        end
        c.com = req_com; c.cea = req_cea; c.cch = req_cch; c.csize = req_csize;
        cmd_q.push_back(c);
        nb[c.tag] = 1'b1;
        delta = -1;
      end
      if (ha_rvalid) begin
        idx = int'(ha_rtag);
        good = ((^ha_rtag) ^ ha_rtagpar) && (idx < NUM_TAGS);
        if (good) good = mbusy[idx];
        if (good) begin
          rsp_t r;
          r.tag = ha_rtag; r.code = ha_response;
          rsp_q.push_back(r);
          nb[idx] = 1'b0;
        end else begin
          merr = 1'b1;
        end
        delta += int'($signed(ha_rcredits));
      end
      mbusy = nb;
      mcred = mcred + delta;
      if (mcred < 0) mcred = 0;
      if (mcred > mmax) mcred = mmax;
    end
  end

  // Compare DUT outputs to the scoreboard on the inactive edge.
  always @(negedge clock) begin
    if (chk_en) begin
      if (ah_cvalid) begin
        if (cmd_q.size() == 0) check("ah_cvalid_unexpected", 1, 0);
        else begin
          cmd_t c;
          c = cmd_q.pop_front();
          check("ah_ctag", ah_ctag, c.tag);
          check("ah_ctagpar", ah_ctagpar, ~^c.tag);
          check("ah_com", ah_com, c.com);
          check("ah_compar", ah_compar, ~^c.com);
          check("ah_cea", ah_cea, c.cea);
          check("ah_ceapar", ah_ceapar, ~^c.cea);
          check("ah_cch", ah_cch, c.cch);
          check("ah_csize", ah_csize, c.csize);
          check("ah_cabt", ah_cabt, 0);
        end
      end else if (cmd_q.size() != 0) begin
        check("ah_cvalid_missing", 0, 1);
        cmd_q.delete();
      end
      if (rsp_valid) begin
        if (rsp_q.size() == 0) check("rsp_valid_unexpected", 1, 0);
        else begin
          rsp_t r;
          r = rsp_q.pop_front();
          check("rsp_tag", rsp_tag, r.tag);
          check("rsp_code", rsp_code, r.code);
        end
      end else if (rsp_q.size() != 0) begin
        check("rsp_valid_missing", 0, 1);
        rsp_q.delete();
      end
      check("req_ready", req_ready, model_ready());
      check("outstanding", outstanding, $countones(mbusy));
      check("err_tag", err_tag, merr);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_rsp(input int tag, input bit par_ok, input logic [7:0] code, input int rc);
    ha_rvalid   = 1'b1;
    ha_rtag     = 8'(tag);
    ha_rtagpar  = par_ok ? ~^(8'(tag)) : ^(8'(tag));
    ha_response = code;
    ha_rcredits = 9'(rc);
  endtask

  task automatic clr_rsp();
    ha_rvalid = 1'b0; ha_rtag = '0; ha_rtagpar = 1'b0; ha_response = '0; ha_rcredits = '0;
  endtask

  task automatic restart(input logic [7:0] croom);
    enabled = 1'b0; tick();
    ha_croom = croom; enabled = 1'b1; tick(); tick();
  endtask

  initial begin
    rstn = 1'b0; enabled = 1'b0; ha_croom = '0; req_valid = 1'b0;
    req_com = '0; req_cea = '0; req_cch = '0; req_csize = '0;
    clr_rsp();
    tick(); tick();
    check("rst_ah_cvalid", ah_cvalid, 0);
    check("rst_ah_ctagpar", ah_ctagpar, 0);
    check("rst_ah_compar", ah_compar, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_outstanding", outstanding, 0);
    check("rst_err_tag", err_tag, 0);
    check("rst_req_ready", req_ready, 0);

    // Load four credits, issue four back to back, fifth is held.
    rstn = 1'b1; chk_en = 1'b1; ha_croom = 8'd4; enabled = 1'b1;
    tick(); tick();
    req_valid = 1'b1; req_com = capi_pkg::READ_CL_NA; req_cch = 16'h1234;
    for (int i = 0; i < 4; i++) begin
      req_cea = {$urandom, $urandom}; req_csize = 12'(64 << (i % 3));
      tick();
      check("burst_tag", ah_ctag, i);
    end
    check("ready_no_credit", req_ready, 0);
    tick();
    req_valid = 1'b0;

    // Retire tag 2 with a credit, then reissue into it.
    set_rsp(2, 1'b1, capi_pkg::DONE, 1);
    tick(); clr_rsp();
    check("rsp_tag2_valid", rsp_valid, 1);
    check("rsp_tag2", rsp_tag, 2);
    check("out_after_free", outstanding, 3);
    req_valid = 1'b1; req_com = capi_pkg::WRITE_NA; req_cea = 64'hDEAD_BEEF_0000_1000;
    tick(); req_valid = 1'b0;
    check("reuse_tag2", ah_ctag, 2);
    check("out_after_reuse", outstanding, 4);

    // Credits to 1, then issue and retire tag 0 on the same edge.
    set_rsp(3, 1'b1, capi_pkg::PAGED, 1);
    tick();
    set_rsp(0, 1'b1, capi_pkg::FLUSHED, 1);
    req_valid = 1'b1; req_cea = 64'h0123_4567_89AB_CDEF;
    tick(); clr_rsp(); req_valid = 1'b0;
    check("same_cycle_tag", ah_ctag, 3);
    check("same_cycle_ready", req_ready, 1);
    tick();

    // Response to a free tag, then a busy tag with bad parity.
    set_rsp(7, 1'b1, capi_pkg::DONE, 0);
    tick(); clr_rsp();
    check("free_tag_err", err_tag, 1);
    check("free_tag_no_rsp", rsp_valid, 0);
    tick();
    set_rsp(1, 1'b0, capi_pkg::DONE, 0);
    tick(); clr_rsp();
    check("badpar_no_rsp", rsp_valid, 0);
    check("badpar_out", outstanding, 3);
    check("err_sticky", err_tag, 1);

    // Credit saturation at both ends.
    set_rsp(7, 1'b1, capi_pkg::AERROR, 100);
    tick(); clr_rsp();
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req_cea = {$urandom, $urandom}; tick();
    end
    req_valid = 1'b0;
    check("sat_max_ready", req_ready, 0);
    set_rsp(7, 1'b1, capi_pkg::DONE, 3);
    tick();
    set_rsp(7, 1'b1, capi_pkg::DONE, -50);
    tick(); clr_rsp();
    check("sat_min_ready", req_ready, 0);
    set_rsp(7, 1'b1, capi_pkg::DONE, 1);
    tick(); clr_rsp();
    check("credit_back_ready", req_ready, 1);

    // Flush with tags busy, then reload two credits.
    enabled = 1'b0;
    tick();
    check("flush_cvalid", ah_cvalid, 0);
    check("flush_out", outstanding, 0);
    check("flush_ready", req_ready, 0);
    ha_croom = 8'd2; enabled = 1'b1;
    tick(); tick();
    req_valid = 1'b1;
    tick();
    check("reload_tag0", ah_ctag, 0);
    tick(); tick();
    req_valid = 1'b0;
    check("reload_limit", req_ready, 0);

    // Fill the whole pool with READ_CL_NA at address 0.
    restart(8'd40);
    req_valid = 1'b1; req_com = capi_pkg::READ_CL_NA; req_cea = 64'h0;
    for (int i = 0; i < NUM_TAGS; i++) begin
      tick();
      check("fill_tag", ah_ctag, i);
      check("fill_compar", ah_compar, 1);
      check("fill_ceapar", ah_ceapar, 1);
    end
    check("pool_empty_ready", req_ready, 0);
    tick();
    req_valid = 1'b0;
    tick();
    enabled = 1'b0;
    tick(); tick();
    check("cmd_q_drained", cmd_q.size(), 0);
    check("rsp_q_drained", rsp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
